// File: rtl/huff_pkg.sv
// Shared types and sizes for the bit-serial JPEG Huffman symbol decoder.
package huff_pkg;

    localparam int unsigned T1_DEPTH     = 16;
    localparam int unsigned T2_DEPTH     = 54;
    localparam int unsigned MAX_CODE_LEN = 8;
    localparam int unsigned MAX_SIZE     = 11;
    localparam int unsigned COEF_W       = 12;
    localparam int unsigned T1_AW        = 4;
    localparam int unsigned T2_AW        = 6;
    localparam int unsigned LEN_W        = 4;
    localparam int unsigned IDX_W        = 6;
    localparam int unsigned MAG_W        = 11;
    localparam int unsigned SIZE_W       = 4;
    localparam int unsigned RUN_W        = 2;

    typedef enum logic [1:0] {
        CODE = 2'd0,
        MAG  = 2'd1,
        ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic [8:0] maxcode;
        logic [5:0] base;
    } t1_entry_t;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [RUN_W-1:0]  run;
    } t2_entry_t;

    typedef struct packed {
        logic [RUN_W-1:0]  run;
        logic [SIZE_W-1:0] size;
        logic [COEF_W-1:0] coeff;
        logic [IDX_W-1:0]  idx;
        logic              dc;
    } sym_rec_t;

    // JPEG magnitude category decode: a leading 0 marks a negative value.
    function automatic logic [COEF_W-1:0] mag_to_coeff(input logic [MAG_W-1:0] mag,
                                                       input logic [SIZE_W-1:0] size);
        logic [COEF_W-1:0] m;
        m = COEF_W'(mag);
        if (size == '0)
            return '0;
        else if (mag[SIZE_W'(size - SIZE_W'(1))])
            return m;
        else
            return m - ((COEF_W'(1) << size) - COEF_W'(1));
    endfunction

endpackage

// File: rtl/huff_symbol_decoder_if.sv
// Bitstream, table-load and symbol-record signals of the Huffman decoder.
interface huff_symbol_decoder_if;
    import huff_pkg::*;

    logic                bitstream_s1;
    logic                bit_valid_s1;
    logic                rw1_en_s1;
    logic [T1_AW-1:0]    t1_addr_s1;
    logic [8:0]          maxcode_v1;
    logic [5:0]          base_v1;
    logic                rw2_en_s1;
    logic [T2_AW-1:0]    t2_addr_s1;
    logic [SIZE_W-1:0]   coeff_size_v1;
    logic [RUN_W-1:0]    run_length_v1;

    logic                sym_valid_s1;
    logic                sym_dc_s1;
    logic [RUN_W-1:0]    sym_run_s1;
    logic [SIZE_W-1:0]   sym_size_s1;
    logic [COEF_W-1:0]   sym_coeff_s1;
    logic [IDX_W-1:0]    coeff_idx_s1;
    logic                block_done_s1;
    logic                code_err_s1;

    modport master (
        output bitstream_s1, bit_valid_s1, rw1_en_s1, t1_addr_s1, maxcode_v1, base_v1,
               rw2_en_s1, t2_addr_s1, coeff_size_v1, run_length_v1,
        input  sym_valid_s1, sym_dc_s1, sym_run_s1, sym_size_s1, sym_coeff_s1,
               coeff_idx_s1, block_done_s1, code_err_s1
    );

    modport slave (
        input  bitstream_s1, bit_valid_s1, rw1_en_s1, t1_addr_s1, maxcode_v1, base_v1,
               rw2_en_s1, t2_addr_s1, coeff_size_v1, run_length_v1,
        output sym_valid_s1, sym_dc_s1, sym_run_s1, sym_size_s1, sym_coeff_s1,
               coeff_idx_s1, block_done_s1, code_err_s1
    );

endinterface

// File: rtl/huff_tables.sv
// Huffman lookup tables: maxcode/base (T1) and size/run (T2); unreset, async read.
module huff_tables
    import huff_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_t1_we,
    input  logic [T1_AW-1:0] i_t1_waddr,
    input  t1_entry_t        i_t1_wdata,
    input  logic [T1_AW-1:0] i_t1_raddr,
    output t1_entry_t        o_t1_rdata_c,
    input  logic             i_t2_we,
    input  logic [T2_AW-1:0] i_t2_waddr,
    input  t2_entry_t        i_t2_wdata,
    input  logic [T2_AW-1:0] i_t2_raddr,
    output t2_entry_t        o_t2_rdata_c
);

    t1_entry_t r_t1 [T1_DEPTH];
    t2_entry_t r_t2 [T2_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_t1_we)
            r_t1[i_t1_waddr] <= i_t1_wdata;
        if (i_t2_we && (i_t2_waddr < T2_AW'(T2_DEPTH)))
            r_t2[i_t2_waddr] <= i_t2_wdata;
    end

    assign o_t1_rdata_c = r_t1[i_t1_raddr];
    // Out-of-range T2 reads return zero; the decoder flags them as errors anyway.
    assign o_t2_rdata_c = (i_t2_raddr < T2_AW'(T2_DEPTH)) ? r_t2[i_t2_raddr] : '0;

endmodule

// File: rtl/huff_symbol_decoder.sv
// Bit-serial canonical Huffman decoder producing one coefficient record per symbol.
module huff_symbol_decoder
    import huff_pkg::*;
(
    input  logic                  phi1,
    input  logic                  reset_s1,
    huff_symbol_decoder_if.slave  io_bus
);

    state_t                  r_state, w_state_nxt;
    logic                    r_dc, w_dc_nxt;
    logic [MAX_CODE_LEN-2:0] r_code, w_code_nxt;
    logic [LEN_W-1:0]        r_len, w_len_nxt;
    logic [MAG_W-2:0]        r_mag, w_mag_nxt;
    logic [SIZE_W-1:0]       r_cnt, w_cnt_nxt;
    logic [RUN_W-1:0]        r_run_l, w_run_l_nxt;
    logic [SIZE_W-1:0]       r_size_l, w_size_l_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    sym_rec_t                r_rec, w_rec_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_err, w_err_nxt;

    logic [MAX_CODE_LEN-1:0] w_code_n;
    logic [LEN_W-1:0]        w_len_n;
    logic [MAG_W-1:0]        w_mag_n;
    logic [SIZE_W-1:0]       w_cnt_n;
    logic [T2_AW-1:0]        w_t2_raddr;
    t1_entry_t               w_t1;
    t2_entry_t               w_t2;
    logic                    w_match;
    logic                    w_emit, w_fail;
    logic [RUN_W-1:0]        w_e_run;
    logic [SIZE_W-1:0]       w_e_size;
    logic [COEF_W-1:0]       w_e_coeff;
    logic [IDX_W:0]          w_idx_sum;

    huff_tables u_tables (
        .i_clk        (phi1),
        .i_t1_we      (io_bus.rw1_en_s1),
        .i_t1_waddr   (io_bus.t1_addr_s1),
        .i_t1_wdata   ({io_bus.maxcode_v1, io_bus.base_v1}),
        .i_t1_raddr   ({r_dc, r_len[2:0]}),
        .o_t1_rdata_c (w_t1),
        .i_t2_we      (io_bus.rw2_en_s1),
        .i_t2_waddr   (io_bus.t2_addr_s1),
        .i_t2_wdata   ({io_bus.coeff_size_v1, io_bus.run_length_v1}),
        .i_t2_raddr   (w_t2_raddr),
        .o_t2_rdata_c (w_t2)
    );

    assign w_code_n   = {r_code, io_bus.bitstream_s1};
    assign w_len_n    = r_len + LEN_W'(1);
    assign w_mag_n    = {r_mag, io_bus.bitstream_s1};
    assign w_cnt_n    = r_cnt + SIZE_W'(1);
    assign w_t2_raddr = w_t1.base + w_code_n[T2_AW-1:0];
    assign w_match    = !w_t1.maxcode[8] && (w_code_n <= w_t1.maxcode[7:0]);

    always_ff @(posedge phi1 or posedge reset_s1) begin
        if (reset_s1) begin
            r_state  <= CODE;
            r_dc     <= 1'b1;
            r_code   <= '0;
            r_len    <= '0;
            r_mag    <= '0;
            r_cnt    <= '0;
            r_run_l  <= '0;
            r_size_l <= '0;
            r_idx    <= '0;
            r_rec    <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dc     <= w_dc_nxt;
            r_code   <= w_code_nxt;
            r_len    <= w_len_nxt;
            r_mag    <= w_mag_nxt;
            r_cnt    <= w_cnt_nxt;
            r_run_l  <= w_run_l_nxt;
            r_size_l <= w_size_l_nxt;
            r_idx    <= w_idx_nxt;
            r_rec    <= w_rec_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dc_nxt     = r_dc;
        w_code_nxt   = r_code;
        w_len_nxt    = r_len;
        w_mag_nxt    = r_mag;
        w_cnt_nxt    = r_cnt;
        w_run_l_nxt  = r_run_l;
        w_size_l_nxt = r_size_l;
        w_idx_nxt    = r_idx;
        w_rec_nxt    = r_rec;
        w_valid_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        w_emit       = 1'b0;
        w_fail       = 1'b0;
        w_e_run      = '0;
        w_e_size     = '0;
        w_e_coeff    = '0;
        w_idx_sum    = '0;

        case (r_state)
            CODE: begin
                if (io_bus.bit_valid_s1) begin
                    if (w_match) begin
                        if ((w_t2_raddr >= T2_AW'(T2_DEPTH)) || (w_t2.size > SIZE_W'(MAX_SIZE))) begin
                            w_fail = 1'b1;
                        end else if (w_t2.size == '0) begin
                            w_emit  = 1'b1;
                            w_e_run = w_t2.run;
                        end else begin
                            w_run_l_nxt  = w_t2.run;
                            w_size_l_nxt = w_t2.size;
                            w_mag_nxt    = '0;
                            w_cnt_nxt    = '0;
                            w_code_nxt   = '0;
                            w_len_nxt    = '0;
                            w_state_nxt  = MAG;
                        end
                    end else if (w_len_n == LEN_W'(MAX_CODE_LEN)) begin
                        w_fail = 1'b1;
                    end else begin
                        w_code_nxt = w_code_n[MAX_CODE_LEN-2:0];
                        w_len_nxt  = w_len_n;
                    end
                end
            end
            MAG: begin
                if (io_bus.bit_valid_s1) begin
                    w_mag_nxt = w_mag_n[MAG_W-2:0];
                    w_cnt_nxt = w_cnt_n;
                    if (w_cnt_n == r_size_l) begin
                        w_emit    = 1'b1;
                        w_e_run   = r_run_l;
                        w_e_size  = r_size_l;
                        w_e_coeff = mag_to_coeff(w_mag_n, r_size_l);
                    end
                end
            end
            default: ;
        endcase

        // Record formation and zig-zag index bookkeeping.
        if (w_emit) begin
            w_state_nxt   = CODE;
            w_code_nxt    = '0;
            w_len_nxt     = '0;
            w_mag_nxt     = '0;
            w_cnt_nxt     = '0;
            w_valid_nxt   = 1'b1;
            w_rec_nxt.run   = w_e_run;
            w_rec_nxt.size  = w_e_size;
            w_rec_nxt.coeff = w_e_coeff;
            w_rec_nxt.dc    = r_dc;
            if (r_dc) begin
                w_idx_nxt     = '0;
                w_rec_nxt.idx = '0;
                w_dc_nxt      = 1'b0;
            end else if ((w_e_run == '0) && (w_e_size == '0)) begin
                w_rec_nxt.idx = r_idx;
                w_done_nxt    = 1'b1;
                w_dc_nxt      = 1'b1;
            end else begin
                w_idx_sum = (IDX_W+1)'(r_idx) + (IDX_W+1)'(w_e_run) + (IDX_W+1)'(1);
                if (w_idx_sum > (IDX_W+1)'(63)) begin
                    w_fail = 1'b1;
                end else begin
                    w_idx_nxt     = w_idx_sum[IDX_W-1:0];
                    w_rec_nxt.idx = w_idx_sum[IDX_W-1:0];
                    if (w_idx_sum == (IDX_W+1)'(63)) begin
                        w_done_nxt = 1'b1;
                        w_dc_nxt   = 1'b1;
                    end
                end
            end
        end

        if (w_fail) begin
            w_state_nxt = ERR;
            w_err_nxt   = 1'b1;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            w_rec_nxt   = r_rec;
        end
    end

    assign io_bus.sym_valid_s1  = r_valid;
    assign io_bus.sym_dc_s1     = r_rec.dc;
    assign io_bus.sym_run_s1    = r_rec.run;
    assign io_bus.sym_size_s1   = r_rec.size;
    assign io_bus.sym_coeff_s1  = r_rec.coeff;
    assign io_bus.coeff_idx_s1  = r_rec.idx;
    assign io_bus.block_done_s1 = r_done;
    assign io_bus.code_err_s1   = r_err;

endmodule

// File: tb/tb_huff_symbol_decoder.sv
// Directed bench for huff_symbol_decoder with hand-computed expected records.
module tb_huff_symbol_decoder;
    import huff_pkg::*;

    logic phi1 = 1'b0;
    logic reset_s1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 phi1 = ~phi1;

    huff_symbol_decoder_if bus ();

    huff_symbol_decoder dut (
        .phi1     (phi1),
        .reset_s1 (reset_s1),
        .io_bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_t1(input logic [3:0] a, input logic [8:0] mc, input logic [5:0] base);
        bus.rw1_en_s1  = 1'b1;
        bus.t1_addr_s1 = a;
        bus.maxcode_v1 = mc;
        bus.base_v1    = base;
        @(posedge phi1); #1;
        bus.rw1_en_s1  = 1'b0;
    endtask

    task automatic wr_t2(input logic [5:0] a, input logic [3:0] size, input logic [1:0] run);
        bus.rw2_en_s1     = 1'b1;
        bus.t2_addr_s1    = a;
        bus.coeff_size_v1 = size;
        bus.run_length_v1 = run;
        @(posedge phi1); #1;
        bus.rw2_en_s1     = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset_s1 = 1'b1;
        #1;
        chk({tag, "_valid"}, 32'(bus.sym_valid_s1), 32'd0);
        chk({tag, "_err"},   32'(bus.code_err_s1),  32'd0);
        chk({tag, "_coeff"}, 32'(bus.sym_coeff_s1), 32'd0);
        chk({tag, "_idx"},   32'(bus.coeff_idx_s1), 32'd0);
        @(posedge phi1); #1;
        reset_s1 = 1'b0;
    endtask

    task automatic send(input string tag, input logic b, input logic exp_v);
        bus.bitstream_s1 = b;
        bus.bit_valid_s1 = 1'b1;
        @(posedge phi1); #1;
        bus.bit_valid_s1 = 1'b0;
        chk({tag, "_valid"}, 32'(bus.sym_valid_s1), 32'(exp_v));
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge phi1); #1;
            chk({tag, "_idle_valid"}, 32'(bus.sym_valid_s1), 32'd0);
        end
    endtask

    task automatic chk_rec(input string tag, input logic dc, input logic [1:0] run,
                           input logic [3:0] size, input logic [11:0] coeff,
                           input logic [5:0] idx, input logic done);
        chk({tag, "_dc"},    32'(bus.sym_dc_s1),     32'(dc));
        chk({tag, "_run"},   32'(bus.sym_run_s1),    32'(run));
        chk({tag, "_size"},  32'(bus.sym_size_s1),   32'(size));
        chk({tag, "_coeff"}, 32'(bus.sym_coeff_s1),  32'(coeff));
        chk({tag, "_idx"},   32'(bus.coeff_idx_s1),  32'(idx));
        chk({tag, "_done"},  32'(bus.block_done_s1), 32'(done));
    endtask

    // DC symbol: code "10" then magnitude bits m2 m1 m0.
    task automatic send_dc(input string tag, input logic [2:0] m);
        send(tag, 1'b1, 1'b0);
        send(tag, 1'b0, 1'b0);
        send(tag, m[2], 1'b0);
        send(tag, m[1], 1'b0);
        send(tag, m[0], 1'b1);
    endtask

    initial begin
        reset_s1          = 1'b1;
        bus.bitstream_s1  = 1'b0;
        bus.bit_valid_s1  = 1'b0;
        bus.rw1_en_s1     = 1'b0;
        bus.t1_addr_s1    = '0;
        bus.maxcode_v1    = '0;
        bus.base_v1       = '0;
        bus.rw2_en_s1     = 1'b0;
        bus.t2_addr_s1    = '0;
        bus.coeff_size_v1 = '0;
        bus.run_length_v1 = '0;

        // Tables load while reset is held.
        for (int i = 0; i < 16; i++) wr_t1(4'(i), 9'h100, 6'd0);
        wr_t1(4'd9, 9'h002, 6'd0);
        wr_t2(6'd2, 4'd3, 2'd0);
        wr_t1(4'd1, 9'h001, 6'd10);
        wr_t2(6'd10, 4'd0, 2'd0);
        wr_t2(6'd11, 4'd1, 2'd2);
        do_reset("rst0");
        chk("rst0_done", 32'(bus.block_done_s1), 32'd0);

        send_dc("dcp5", 3'b101);
        chk_rec("dcp5", 1'b1, 2'd0, 4'd3, 12'h005, 6'd0, 1'b0);
        idle("dcp5", 1);

        send("ac", 1'b0, 1'b0);
        send("ac", 1'b1, 1'b0);
        send("ac", 1'b1, 1'b1);
        chk_rec("ac", 1'b0, 2'd2, 4'd1, 12'h001, 6'd3, 1'b0);

        send("eob", 1'b0, 1'b0);
        send("eob", 1'b0, 1'b1);
        chk_rec("eob", 1'b0, 2'd0, 4'd0, 12'h000, 6'd3, 1'b1);

        send_dc("dcm5", 3'b010);
        chk_rec("dcm5", 1'b1, 2'd0, 4'd3, 12'hFFB, 6'd0, 1'b0);

        // Stall three cycles in the middle of the magnitude field.
        do_reset("rst1");
        send("stall", 1'b1, 1'b0);
        send("stall", 1'b0, 1'b0);
        send("stall", 1'b0, 1'b0);
        idle("stall", 3);
        send("stall", 1'b1, 1'b0);
        send("stall", 1'b0, 1'b1);
        chk_rec("stall", 1'b1, 2'd0, 4'd3, 12'hFFB, 6'd0, 1'b0);

        // Partial symbol discarded by reset, then a clean replay.
        do_reset("rst2");
        send("part", 1'b1, 1'b0);
        send("part", 1'b0, 1'b0);
        send("part", 1'b1, 1'b0);
        do_reset("rst3");
        send_dc("replay", 3'b101);
        chk_rec("replay", 1'b1, 2'd0, 4'd3, 12'h005, 6'd0, 1'b0);

        // Zero skips of run 3 walk idx to 60, then run 2 lands exactly on 63.
        wr_t2(6'd10, 4'd0, 2'd3);
        for (int k = 1; k <= 15; k++) begin
            send("zskip", 1'b0, 1'b0);
            send("zskip", 1'b0, 1'b1);
            chk("zskip_idx", 32'(bus.coeff_idx_s1), 32'(4 * k));
            chk("zskip_done", 32'(bus.block_done_s1), 32'd0);
        end
        chk_rec("zskip60", 1'b0, 2'd3, 4'd0, 12'h000, 6'd60, 1'b0);
        send("last", 1'b0, 1'b0);
        send("last", 1'b1, 1'b0);
        send("last", 1'b1, 1'b1);
        chk_rec("last", 1'b0, 2'd2, 4'd1, 12'h001, 6'd63, 1'b1);
        send_dc("dcnext", 3'b101);
        chk_rec("dcnext", 1'b1, 2'd0, 4'd3, 12'h005, 6'd0, 1'b0);

        // No AC codes at any length: the eighth bit raises the sticky error.
        wr_t1(4'd1, 9'h100, 6'd0);
        for (int k = 1; k <= 7; k++) begin
            send("inval", 1'b0, 1'b0);
            chk("inval_err_early", 32'(bus.code_err_s1), 32'd0);
        end
        send("inval", 1'b0, 1'b0);
        chk("inval_err", 32'(bus.code_err_s1), 32'd1);
        send("inval_post", 1'b1, 1'b0);
        send("inval_post", 1'b0, 1'b0);
        chk("inval_sticky", 32'(bus.code_err_s1), 32'd1);
        do_reset("rst4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/huff_symbol_decoder.md
Name: huff_symbol_decoder

Overview:
- Bit-serial JPEG Huffman symbol decoder; the stage directly downstream of the bitstream/table-init source.
- Holds lookup table 1 (maxcode/base, DC and AC) and lookup table 2 (coeff_size/run_length), both loaded during initialization.
- During decode, consumes bitstream_s1 one bit per cycle, resolves canonical Huffman codes and reads magnitude bits.
- Emits one (run, size, signed coefficient, index) record per symbol to the downstream coefficient store.

Parameters:
- T2_DEPTH, 54, table 2 entries.
- MAX_CODE_LEN, 8, longest Huffman code in bits.
- MAX_SIZE, 11, largest legal coeff_size.
- COEF_W, 12, signed coefficient output width.

Ports:
- phi1  in  1  single clock; all flops on posedge.
- reset_s1  in  1  asynchronous, active-high reset.
- bitstream_s1  in  1  serial JPEG bit.
- bit_valid_s1  in  1  bitstream_s1 is valid this cycle.
- rw1_en_s1  in  1  table 1 write enable.
- t1_addr_s1  in  4  table 1 index: {dc, len-1}; 0-7 AC, 8-15 DC.
- maxcode_v1  in  9  table 1 maxcode; bit 8 set means no codes of this length.
- base_v1  in  6  table 1 base (valptr - mincode, mod 64).
- rw2_en_s1  in  1  table 2 write enable.
- t2_addr_s1  in  6  table 2 address.
- coeff_size_v1  in  4  table 2 coefficient size.
- run_length_v1  in  2  table 2 run length.
- sym_valid_s1  out  1  one-cycle pulse; record valid.
- sym_dc_s1  out  1  record is a DC symbol.
- sym_run_s1  out  2  run length.
- sym_size_s1  out  4  coefficient size.
- sym_coeff_s1  out  COEF_W  signed coefficient.
- coeff_idx_s1  out  6  zig-zag index of this coefficient.
- block_done_s1  out  1  pulse with the last record of an 8x8 block.
- code_err_s1  out  1  sticky error.

Behaviour:
- Reset: all outputs 0; FSM to CODE with dc = 1; code register, length counter, index and magnitude are cleared.
- Reset does not clear tables. Table writes are accepted on posedge phi1 whether reset_s1 is high or low.
- Table reads are combinational. A same-cycle write and read of one address returns the old data.
- Bit consumption: only cycles with bit_valid_s1 = 1 advance. When bit_valid_s1 = 0, all state holds and sym_valid_s1 = 0.
- States: CODE, MAG, ERR.
- CODE:
  - Compute code_n = {code, bit} and len_n = len + 1, then read T1[{dc, len_n-1}].
  - Match when maxcode[8] = 0 and code_n <= maxcode[7:0].
  - On match, form addr = (base + code_n[5:0]) mod 64 and read T2[addr].
  - addr >= T2_DEPTH goes to ERR.
  - size > MAX_SIZE goes to ERR.
  - size = 0: emit on the next edge and stay in CODE.
  - size != 0: latch run and size, go to MAG.
  - No match with len_n = MAX_CODE_LEN goes to ERR.
- MAG:
  - Shift bits MSB-first into mag[10:0] until size bits are collected, then emit.
  - Value = mag if mag[size-1] = 1; otherwise mag - (2^size - 1). Sign-extend to COEF_W.
- Emit:
  - sym_* outputs are registered and valid the cycle after the final consumed bit of the symbol.
  - Latency is exactly 1 cycle after bit len + size.
  - The code register and length counter clear.
- Index:
  - A DC symbol sets idx = 0, then dc becomes 0.
  - An AC symbol gives idx = idx + run + 1.
  - An AC symbol with run = 0 and size = 0 is EOB: coeff 0, idx unchanged, block_done_s1 = 1.
  - An AC symbol with size = 0 and run != 0 is a zero skip: coeff 0.
  - Reaching idx = 63 asserts block_done_s1.
  - idx + run + 1 > 63 goes to ERR.
  - After block_done_s1, dc becomes 1.
- ERR: code_err_s1 = 1, no further records; the only exit is reset_s1.
- Reset mid-symbol: the partial code or magnitude is discarded; the next valid bit starts a fresh DC code.

Decomposition:
- Shared package huff_pkg:
  - State enum CODE/MAG/ERR.
  - T1_DEPTH = 16, T2_DEPTH, MAX_CODE_LEN, MAX_SIZE, COEF_W.
  - A record typedef {run, size, coeff, idx, dc}.
- One sub-module, huff_tables: the two register arrays with write ports and combinational read ports.
- FSM and arithmetic remain in the top module.

Test Plan:
- DC +5:
  - Setup: T1[8] = 9'h100; T1[9] = {9'h002, 6'd0}; T2[2] = size 3, run 0.
  - Stimulus: bits 1,0,1,0,1.
  - Required: sym_valid_s1 one cycle after the 5th bit; dc = 1, coeff = 12'h005, idx = 0.
- DC -5: same tables, bits 1,0,0,1,0 -> coeff = 12'hFFB.
- AC then EOB:
  - Setup: T1[1] = {9'h001, 6'd10}; T2[10] = size 0, run 0; T2[11] = size 1, run 2.
  - Stimulus: after the DC symbol, bits 0,1,1 then 0,0.
  - Required: first record idx = 3, coeff = 1; second record EOB with block_done_s1 = 1; the next symbol decodes as DC.
- Invalid code: all AC maxcode = 9'h100; 8 AC bits -> code_err_s1 = 1 after the 8th bit, no sym_valid_s1.
- Stall: bit_valid_s1 low for 3 cycles mid-magnitude -> same record as without the stall, delayed by 3 cycles.
- Reset mid-symbol:
  - Stimulus: reset after 3 bits; tables persist; replay the DC +5 bits.
  - Required: coeff = 5, no spurious record.
